// File: rtl/stack.sv
// stack -- register-based LIFO stack whose push duplicates the top entry.
//
// Entry 0 is the top. A push copies every entry one place deeper and keeps
// entry 0, so the top is duplicated. A pop moves every entry one place
// shallower and fills the bottom entry with 0. A write replaces entry 0
// only. Entries at or beyond count always hold 0, so top and next read 0
// whenever they are not backed by valid data.
//
// Parameters
//   WIDTH   data word width in bits
//   DEPTH   number of entries (at most 63, count is 6 bits)
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset: clears entries, count, error
//   push     duplicate the top entry
//   pop      discard the top entry
//   write    overwrite the top entry with value
//   value    data for write
//   top      entry 0 (combinational)
//   next     entry 1 (combinational)
//   count    number of valid entries, 0..DEPTH
//   error    high for one cycle after an illegal operation
module stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             write,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [5:0]       count,
  output logic             error
);

  localparam logic [5:0] FULL = 6'(DEPTH);

  logic [WIDTH-1:0] ent_p0 [DEPTH];
  logic [5:0]       count_p0;
  logic             error_p0;

  logic multi;
  logic empty;
  logic full;
  logic do_write;
  logic do_push;
  logic do_pop;
  logic illegal;

  // Operation decode: any two requests together are rejected outright, and
  // a lone push/pop that would overflow/underflow is rejected as well.
  always_comb begin
    multi    = (push & pop) | (push & write) | (pop & write);
    empty    = (count_p0 == 6'd0);
    full     = (count_p0 == FULL);
    do_write = write & ~multi;
    do_push  = push  & ~multi & ~full;
    do_pop   = pop   & ~multi & ~empty;
    illegal  = multi | (push & ~multi & full) | (pop & ~multi & empty);
  end

  // State register stage: entries, count and the registered error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_p0[i] <= '0;
      end
      count_p0 <= 6'd0;
      error_p0 <= 1'b0;
    end else begin
      error_p0 <= illegal;
      if (do_write) begin
        ent_p0[0] <= value;
        if (empty) begin
          count_p0 <= 6'd1;
        end
      end else if (do_push) begin
        // entry 0 is left alone, which is what duplicates the top
        for (int i = 1; i < DEPTH; i++) begin
          ent_p0[i] <= ent_p0[i-1];
        end
        count_p0 <= count_p0 + 6'd1;
      end else if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          ent_p0[i] <= ent_p0[i+1];
        end
        ent_p0[DEPTH-1] <= '0;
        count_p0 <= count_p0 - 6'd1;
      end
    end
  end

  // Output stage: read ports come straight off the entry registers.
  assign top   = ent_p0[0];
  assign count = count_p0;
  assign error = error_p0;

  generate
    if (DEPTH > 1) begin : g_next
      assign next = ent_p0[1];
    end else begin : g_next_none
      assign next = '0;
    end
  endgenerate

endmodule

// File: tb/tb_stack.sv
// tb_stack -- self-checking bench for stack: a table of single-cycle
// operations with expected results, then hand-written sequences for the
// full-stack, drain and asynchronous-reset corner cases. Expected results
// go into a scoreboard queue when the stimulus is driven and are compared
// one clock later when the DUT shows the result.
module tb_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             push    = 1'b0;
  logic             pop     = 1'b0;
  logic             write   = 1'b0;
  logic [WIDTH-1:0] value   = '0;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [5:0]       count;
  logic             error;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .write  (write),
    .value  (value),
    .top    (top),
    .next   (next),
    .count  (count),
    .error  (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        p;
    logic        q;
    logic        w;
    logic [31:0] v;
    logic [31:0] etop;
    logic [31:0] enext;
    logic [31:0] ecount;
    logic [31:0] eerr;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] etop;
    logic [31:0] enext;
    logic [31:0] ecount;
    logic [31:0] eerr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", tag, act, req);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] et, input logic [31:0] en,
                           input logic [31:0] ec, input logic [31:0] ee);
    cmp({tag, ".top"},   32'(top),   et);
    cmp({tag, ".next"},  32'(next),  en);
    cmp({tag, ".count"}, 32'(count), ec);
    cmp({tag, ".error"}, 32'(error), ee);
  endtask

  task automatic add(input logic p, input logic q, input logic w, input logic [31:0] v,
                     input logic [31:0] et, input logic [31:0] en,
                     input logic [31:0] ec, input logic [31:0] ee);
    vec_t r;
    r.p = p; r.q = q; r.w = w; r.v = v;
    r.etop = et; r.enext = en; r.ecount = ec; r.eerr = ee;
    vecs.push_back(r);
  endtask

  // Drive one operation, queue its expectation, compare one clock later.
  task automatic step(input string tag, input logic p, input logic q, input logic w,
                      input logic [31:0] v, input logic [31:0] et, input logic [31:0] en,
                      input logic [31:0] ec, input logic [31:0] ee);
    exp_t e;
    @(negedge clock);
    push  = p;
    pop   = q;
    write = w;
    value = v;
    e.tag = tag; e.etop = et; e.enext = en; e.ecount = ec; e.eerr = ee;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_all(e.tag, e.etop, e.enext, e.ecount, e.eerr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // push, pop, write, value -> top, next, count, error
    add(0, 0, 1, 1,  1, 0, 1, 0);
    add(0, 0, 1, 2,  2, 0, 1, 0);
    add(1, 0, 0, 0,  2, 2, 2, 0);
    add(0, 0, 1, 3,  3, 2, 2, 0);
    add(1, 0, 0, 0,  3, 3, 3, 0);
    add(0, 0, 1, 4,  4, 3, 3, 0);
    add(0, 1, 0, 0,  3, 2, 2, 0);
    add(0, 1, 0, 0,  2, 0, 1, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 0, 1);   // underflow
    add(0, 0, 0, 0,  0, 0, 0, 0);   // idle clears error
    add(0, 0, 1, 5,  5, 0, 1, 0);
    add(1, 0, 0, 0,  5, 5, 2, 0);
    add(0, 0, 1, 6,  6, 5, 2, 0);
    add(1, 1, 0, 0,  6, 5, 2, 1);   // push+pop
    add(1, 0, 1, 9,  6, 5, 2, 1);   // write+push
    add(0, 1, 1, 9,  6, 5, 2, 1);   // write+pop
    add(0, 0, 0, 0,  6, 5, 2, 0);
    add(0, 1, 0, 0,  5, 0, 1, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 1, 8,  8, 0, 1, 0);   // legal op clears error
    add(0, 1, 0, 0,  0, 0, 0, 0);

    // Reset state, held across an edge with a push pending.
    push = 1'b1;
    #2;
    check_all("reset_async", 0, 0, 0, 0);
    @(posedge clock);
    #1;
    check_all("reset_held", 0, 0, 0, 0);
    @(negedge clock);
    push = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].p, vecs[i].q, vecs[i].w, vecs[i].v,
           vecs[i].etop, vecs[i].enext, vecs[i].ecount, vecs[i].eerr);
    end

    // Fill to DEPTH with duplicated 7s, overflow, write at full, drain.
    step("fill_w7", 0, 0, 1, 7, 7, 0, 1, 0);
    for (int i = 1; i < DEPTH; i++) begin
      step($sformatf("fill%0d", i), 1, 0, 0, 0, 7, 7, 32'(i + 1), 0);
    end
    step("overflow", 1, 0, 0, 0, 7, 7, DEPTH, 1);
    step("write_full", 0, 0, 1, 3, 3, 7, DEPTH, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      int c;
      c = DEPTH - k;
      step($sformatf("drain%0d", k), 0, 1, 0, 0,
           (c >= 1) ? 7 : 0, (c >= 2) ? 7 : 0, 32'(c), 0);
    end

    // Asynchronous reset pulse between edges with count=3 and error set.
    step("pre_w1", 0, 0, 1, 1, 1, 0, 1, 0);
    step("pre_p1", 1, 0, 0, 0, 1, 1, 2, 0);
    step("pre_p2", 1, 0, 0, 0, 1, 1, 3, 0);
    step("pre_w4", 0, 0, 1, 4, 4, 1, 3, 0);
    step("pre_bad", 1, 1, 0, 0, 4, 1, 3, 1);
    reset_n = 1'b0;
    #1;
    check_all("rst_pulse", 0, 0, 0, 0);
    #1;
    reset_n = 1'b1;
    step("resume", 0, 0, 1, 2, 2, 0, 1, 0);
    step("resume_push", 1, 0, 0, 0, 2, 2, 2, 0);

    @(negedge clock);
    push  = 1'b0;
    pop   = 1'b0;
    write = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
